viterbi_decode: RTL
===================

// Module: viterbi_decode
// PURPOSE
//  Hard-decision Viterbi decoder for the (2,1,2) convolutional code, K=3, generators g1=7 (111), g0=5 (101).
//  Sits directly downstream of the encoder, or of channel/noise injection, and consumes its 2-bit code symbols.
//  Produces the decoded serial bit stream, delayed by a fixed traceback depth, for comparison against the ROM source.
//  Survivor memory uses register exchange: 4 states x TB_DEPTH bits.
// PARAMETERS
//  TB_DEPTH  16  survivor length in symbols (= decode latency in accepted symbols); legal range 8..32
//  PM_WIDTH  6   path-metric width in bits; legal range 4..8
// PORTS
//  clk_sig           in   1  single clock; all state changes on its rising edge
//  reset_sig         in   1  asynchronous reset, active-high
//  code_sig          in   2  received symbol; [1]=u^s1^s2 (g1), [0]=u^s2 (g0)
//  code_valid_sig    in   1  code_sig is valid this cycle; symbol is accepted when high
//  decode_sig        out  1  decoded bit
//  decode_valid_sig  out  1  decode_sig is valid this cycle (one-cycle pulse per output bit)
//  min_metric_sig    out  PM_WIDTH  pre-normalisation minimum metric of the latest step (channel-quality monitor)
// BEHAVIOUR
//  Encoder state S={s1,s2}; s1 is the most recent input bit. Transition ps={s1,s2} --u--> ns={u,s1}.
//  - Expected output for that transition: c1=u^s1^s2, c0=u^s2.
//  - Predecessors of ns={u,a}: {a,0} and {a,1}.
//  Branch metric = Hamming distance(code_sig, expected {c1,c0}), range 0..2.
//  ACS, on each accepted symbol:
//  - cand = PM[ps] + BM, saturating at 2^PM_WIDTH-1.
//  - Select the smaller candidate.
//  - Tie: pick the predecessor with s2=0.
//  Normalisation in the same cycle:
//  - m = min of the 4 new metrics.
//  - Store PM_new - m, so the best metric is always 0.
//  - min_metric_sig <= m.
//  Survivor update: surv[ns] <= {surv[selected ps][TB_DEPTH-2:0], u}. The newest bit is the LSB.
//  Output, registered, one cycle after an accepted symbol:
//  - best = state with PM_new==0, lowest index on a tie.
//  - decode_sig <= surv_new[best][TB_DEPTH-1].
//  - decode_valid_sig <= 1 only once the accepted count reaches TB_DEPTH.
//  Decode latency: bit k is presented on the cycle after symbol k+TB_DEPTH-1 is accepted (k counted from 0).
//  code_valid_sig low: metrics, survivors and counter hold; decode_valid_sig <= 0.
//  Symbols may arrive back-to-back, one per cycle.
//  Accepted-symbol counter: 0..TB_DEPTH, saturates at TB_DEPTH and never wraps.
//  Reset values, asynchronous, including reset asserted mid-stream:
//  - Outputs: decode_sig=0, decode_valid_sig=0, min_metric_sig=0.
//  - Metrics: PM[0]=0, PM[1..3]=2^(PM_WIDTH-1).
//  - Survivors: all 0. Counter: 0.
//  - Partial traceback is discarded.
//  - After release, decoding restarts as if from the start of a stream; the encoder's zero start state is assumed.
//  No stream termination or flush. Trailing TB_DEPTH bits stay internal until more symbols arrive.
// STRUCTURE
//  Shared include conv_code_defs.vh:
//  - generator constants G1=3'b111, G0=3'b101
//  - NUM_STATES=4, K=3
//  - output-bit function, also used by the encoder
//  Sub-module viterbi_acs:
//  - 2 candidate metrics + 2 branch metrics in; saturating add/compare; selected metric + decision bit out.
//  - Instantiated 4x.
//  Top of block: branch-metric logic, min/normalise, register-exchange survivor array, counter, output register.
// TESTING
//  1 Reset: assert reset_sig mid-cycle with random inputs -> all outputs 0 immediately, PM={0,32,32,32} (PM_WIDTH=6).
//  2 Clean stream: encode bits 1,0,1,1,0,0,... (64 bits), back-to-back valid ->
//    first decode_valid_sig one cycle after symbol 15 is accepted; decode_sig=1,0,1,1,...; min_metric_sig=0 throughout.
//  3 Errors: flip one code bit every 10 symbols across 2048 ROM bits ->
//    zero decoded errors; min_metric_sig=1 in the step where each error is first counted.
//  4 Valid gaps: same stream as 2 with random 0-5 idle cycles between symbols ->
//    identical decoded sequence; one decode_valid_sig pulse per accepted symbol after fill.
//  5 Saturation: 5000 random symbols (uncorrelated with any codeword) ->
//    no metric wrap, best metric always 0, output bit-exact to the C/Python golden model with the same tie rule.
//  6 Reset mid-operation: reset at symbol 40 of stream 2, then restart the encoder from state 0 ->
//    first valid output again after 16 accepted symbols, matching the restarted source.

Source files
------------

// File: rtl/viterbi_decode_pkg.sv
// Shared definitions for the K=3, rate-1/2 convolutional code (g1=7, g0=5)
// used by the Viterbi decoder and its add-compare-select units.
package viterbi_decode_pkg;

  localparam int         K          = 3;
  localparam int         NUM_STATES = 2 ** (K - 1);
  localparam logic [2:0] G1         = 3'b111;
  localparam logic [2:0] G0         = 3'b101;

  // Encoder output {c1,c0} for input u leaving state s={s1,s2}
  function automatic logic [1:0] conv_out(input logic u, input logic [1:0] s);
    logic [2:0] w_reg;
    w_reg = {u, s};
    return {^(w_reg & G1), ^(w_reg & G0)};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2)
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] w_x;
    w_x = a ^ b;
    return {1'b0, w_x[1]} + {1'b0, w_x[0]};
  endfunction

endpackage

// File: rtl/viterbi_decode_acs.sv
// Add-compare-select for one trellis state: adds a branch metric to each of
// the two predecessor metrics with saturation, keeps the smaller one.
// On a tie the predecessor with s2=0 (input 0) wins.
module viterbi_decode_acs #(
  parameter int PM_WIDTH = 6
) (
  input  logic [PM_WIDTH-1:0] i_pm0,
  input  logic [PM_WIDTH-1:0] i_pm1,
  input  logic [1:0]          i_bm0,
  input  logic [1:0]          i_bm1,
  output logic [PM_WIDTH-1:0] o_pm,
  output logic                o_dec
);

  localparam logic [PM_WIDTH:0]   SAT_EXT = {1'b0, {PM_WIDTH{1'b1}}};
  localparam logic [PM_WIDTH-1:0] SAT     = {PM_WIDTH{1'b1}};

  logic [PM_WIDTH:0]   w_sum0;
  logic [PM_WIDTH:0]   w_sum1;
  logic [PM_WIDTH-1:0] w_c0;
  logic [PM_WIDTH-1:0] w_c1;

  // Saturating candidate metrics and strict-less-than selection
  always_comb begin
    w_sum0 = {1'b0, i_pm0} + {{(PM_WIDTH-1){1'b0}}, i_bm0};
    w_sum1 = {1'b0, i_pm1} + {{(PM_WIDTH-1){1'b0}}, i_bm1};
    if (w_sum0 > SAT_EXT) begin
      w_c0 = SAT;
    end else begin
      w_c0 = w_sum0[PM_WIDTH-1:0];
    end
    if (w_sum1 > SAT_EXT) begin
      w_c1 = SAT;
    end else begin
      w_c1 = w_sum1[PM_WIDTH-1:0];
    end
    o_dec = (w_c1 < w_c0);
    if (o_dec) begin
      o_pm = w_c1;
    end else begin
      o_pm = w_c0;
    end
  end

endmodule

// File: rtl/viterbi_decode.sv
// Hard-decision Viterbi decoder, K=3 (g1=7, g0=5), register-exchange
// survivor memory of TB_DEPTH bits per state. Decoded bit k is presented
// one cycle after symbol k+TB_DEPTH-1 is accepted.
module viterbi_decode
  import viterbi_decode_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_WIDTH = 6
) (
  input  logic                clk_sig,
  input  logic                reset_sig,
  input  logic [1:0]          code_sig,
  input  logic                code_valid_sig,
  output logic                decode_sig,
  output logic                decode_valid_sig,
  output logic [PM_WIDTH-1:0] min_metric_sig
);

  localparam int                  CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [PM_WIDTH-1:0] PM_INIT = {1'b1, {(PM_WIDTH-1){1'b0}}};

  logic [PM_WIDTH-1:0] r_pm        [NUM_STATES];
  logic [TB_DEPTH-1:0] r_surv      [NUM_STATES];
  logic [CNT_W-1:0]    r_cnt;
  logic                r_decode;
  logic                r_decode_valid;
  logic [PM_WIDTH-1:0] r_min_metric;

  logic [1:0]          w_bm0       [NUM_STATES];
  logic [1:0]          w_bm1       [NUM_STATES];
  logic [PM_WIDTH-1:0] w_pm_acs    [NUM_STATES];
  logic                w_dec       [NUM_STATES];
  logic [PM_WIDTH-1:0] w_pm_norm   [NUM_STATES];
  logic [TB_DEPTH-1:0] w_surv_new  [NUM_STATES];
  logic [PM_WIDTH-1:0] w_min;
  logic [PM_WIDTH-1:0] w_min01;
  logic [PM_WIDTH-1:0] w_min23;
  logic [1:0]          w_best;
  logic [CNT_W-1:0]    w_cnt_next;

  // Branch metrics: state ns={u,a} is reached from {a,0} (bm0) and {a,1} (bm1)
  always_comb begin
    for (int i = 0; i < NUM_STATES; i++) begin
      w_bm0[i] = hamming2(code_sig, conv_out(i[1], {i[0], 1'b0}));
      w_bm1[i] = hamming2(code_sig, conv_out(i[1], {i[0], 1'b1}));
    end
  end

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
    viterbi_decode_acs #(
      .PM_WIDTH (PM_WIDTH)
    ) u_acs (
      .i_pm0 (r_pm[(g % 2) * 2]),
      .i_pm1 (r_pm[(g % 2) * 2 + 1]),
      .i_bm0 (w_bm0[g]),
      .i_bm1 (w_bm1[g]),
      .o_pm  (w_pm_acs[g]),
      .o_dec (w_dec[g])
    );
  end

  // Minimum of the new metrics and normalisation so the best path sits at 0
  always_comb begin
    w_min01 = (w_pm_acs[1] < w_pm_acs[0]) ? w_pm_acs[1] : w_pm_acs[0];
    w_min23 = (w_pm_acs[3] < w_pm_acs[2]) ? w_pm_acs[3] : w_pm_acs[2];
    w_min   = (w_min23 < w_min01) ? w_min23 : w_min01;
    for (int i = 0; i < NUM_STATES; i++) begin
      w_pm_norm[i] = w_pm_acs[i] - w_min;
    end
  end

  // Best state: lowest index whose normalised metric is zero
  always_comb begin
    w_best = 2'd0;
    for (int i = NUM_STATES - 1; i >= 0; i--) begin
      if (w_pm_norm[i] == {PM_WIDTH{1'b0}}) begin
        w_best = 2'(i);
      end else begin
        w_best = w_best;
      end
    end
  end

  // Register exchange: inherit the chosen predecessor's path, append u as LSB
  always_comb begin
    logic [TB_DEPTH-1:0] w_surv_sel;
    for (int i = 0; i < NUM_STATES; i++) begin
      if (w_dec[i]) begin
        w_surv_sel = r_surv[{i[0], 1'b1}];
      end else begin
        w_surv_sel = r_surv[{i[0], 1'b0}];
      end
      w_surv_new[i] = (w_surv_sel << 1) | {{(TB_DEPTH-1){1'b0}}, i[1]};
    end
  end

  // Accepted-symbol count, saturating at TB_DEPTH
  always_comb begin
    if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Trellis state: metrics, survivors and counter advance only on accepted symbols
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i]   <= (i == 0) ? {PM_WIDTH{1'b0}} : PM_INIT;
        r_surv[i] <= {TB_DEPTH{1'b0}};
      end
      r_cnt <= {CNT_W{1'b0}};
    end else if (code_valid_sig) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        r_pm[i]   <= w_pm_norm[i];
        r_surv[i] <= w_surv_new[i];
      end
      r_cnt <= w_cnt_next;
    end
  end

  // Output register: oldest bit of the best survivor, valid once the window is full
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      r_decode       <= 1'b0;
      r_decode_valid <= 1'b0;
      r_min_metric   <= {PM_WIDTH{1'b0}};
    end else if (code_valid_sig) begin
      r_decode       <= w_surv_new[w_best][TB_DEPTH-1];
      r_decode_valid <= (w_cnt_next == CNT_MAX);
      r_min_metric   <= w_min;
    end else begin
      r_decode_valid <= 1'b0;
    end
  end

  assign decode_sig       = r_decode;
  assign decode_valid_sig = r_decode_valid;
  assign min_metric_sig   = r_min_metric;

endmodule
